alu_uart_sequencer: RTL and testbench

Frame controller between the UART receiver/transmitter and the ALU operand registers. It collects three received bytes in order (operand A, operand B, opcode) and pulses the matching register load enable for each. It then waits a fixed ALU settle time, captures the ALU result, and hands it to the UART transmitter. An inter-byte timeout aborts partial frames, and bytes arriving while a result is in flight are dropped and flagged.

---
 rtl/alu_uart_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
// Frame controller sitting between the UART and the ALU operand registers.
// Receives operand A, operand B and an opcode byte, pulses the matching
// register load enable for each, waits for the ALU to settle, then hands
// the captured result to the UART transmitter. Partial frames are aborted
// after an inter-byte timeout; bytes arriving while a result is in flight
// are dropped and flagged as overruns.

module alu_uart_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  load_a,
  output logic                  load_b,
  output logic                  load_op,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  timeout,
  output logic                  overrun,
  output logic [2:0]            state_dbg,
  output logic [7:0]            frame_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  // A zero timeout disables the abort entirely, so the wrapped value of
  // TIMEOUT_LAST is never looked at in that configuration.
  localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LATENCY_LAST = CNT_WIDTH'(ALU_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  logic [2:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_regData;
  logic [DATA_WIDTH-1:0] r_txData;
  logic                  r_loadA;
  logic                  r_loadB;
  logic                  r_loadOp;
  logic                  r_txStart;
  logic                  r_busy;
  logic                  r_timeout;
  logic                  r_overrun;
  logic [7:0]            r_frameCount;

  logic [2:0]            w_nextState;
  logic [CNT_WIDTH-1:0]  w_nextCnt;
  logic                  w_loadA;
  logic                  w_loadB;
  logic                  w_loadOp;
  logic                  w_txStart;
  logic                  w_timeout;
  logic                  w_overrun;
  logic                  w_capture;
  logic                  w_frameDone;

  // Next-state and strobe decode; the single counter serves both the inter-byte timeout and the ALU settle wait.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_loadA     = 1'b0;
    w_loadB     = 1'b0;
    w_loadOp    = 1'b0;
    w_txStart   = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = 1'b0;
    w_capture   = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nextCnt = '0;
        if (rx_valid) begin
          w_loadA     = 1'b1;
          w_nextState = S_WAIT_B;
        end
      end
      S_WAIT_B, S_WAIT_OP: begin
        if (rx_valid) begin
          if (r_state == S_WAIT_B) begin
            w_loadB     = 1'b1;
            w_nextState = S_WAIT_OP;
          end else begin
            w_loadOp    = 1'b1;
            w_nextState = S_EXEC;
          end
          w_nextCnt = '0;
        end else if (TIMEOUT_EN) begin
          if (r_cnt == TIMEOUT_LAST) begin
            w_timeout   = 1'b1;
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + CNT_ONE;
          end
        end
      end
      S_EXEC: begin
        w_overrun = rx_valid;
        if (r_cnt == LATENCY_LAST) begin
          w_capture   = 1'b1;
          w_nextState = S_SEND;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      S_SEND: begin
        w_overrun = rx_valid;
        if (!tx_busy) begin
          w_txStart   = 1'b1;
          w_nextState = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        w_overrun = rx_valid;
        if (tx_done) begin
          w_frameDone = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Register every output so the downstream registers and transmitter see glitch-free one-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_regData    <= '0;
      r_txData     <= '0;
      r_loadA      <= 1'b0;
      r_loadB      <= 1'b0;
      r_loadOp     <= 1'b0;
      r_txStart    <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_frameCount <= 8'd0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_loadA   <= w_loadA;
      r_loadB   <= w_loadB;
      r_loadOp  <= w_loadOp;
      r_txStart <= w_txStart;
      r_timeout <= w_timeout;
      r_overrun <= w_overrun;
      r_busy    <= (w_nextState != S_IDLE);
      if (w_loadA || w_loadB || w_loadOp) begin
        r_regData <= rx_data;
      end
      if (w_capture) begin
        r_txData <= alu_result;
      end
      if (w_frameDone) begin
        r_frameCount <= r_frameCount + 8'd1;
      end
    end
  end

  assign reg_data    = r_regData;
  assign load_a      = r_loadA;
  assign load_b      = r_loadB;
  assign load_op     = r_loadOp;
  assign tx_data     = r_txData;
  assign tx_start    = r_txStart;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign overrun     = r_overrun;
  assign state_dbg   = r_state;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer
// Scoreboard bench for alu_uart_sequencer. The stimulus process drives one
// cycle at a time and a time-based reference model predicts which strobe
// appears on which cycle with which data; a negedge monitor pops and checks.

module tb_alu_uart_sequencer;

  localparam int LAT = 2;
  localparam int TMO = 100;

  typedef struct {
    logic [4:0] kinds;   // {timeout, tx_start, load_op, load_b, load_a}
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_result;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] reg_data;
  logic       load_a;
  logic       load_b;
  logic       load_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout;
  logic       overrun;
  logic [2:0] state_dbg;
  logic [7:0] frame_count;

  logic [63:0] w_outs;
  logic [7:0]  stubA;
  logic [7:0]  stubB;
  logic [7:0]  stubOp;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  expQ[$];
  int   ovrQ[$];

  // Reference model state, expressed as frame progress and event times
  int         mCount = 0;
  int         mLastLoad = 0;
  bit         mInFlight = 0;
  int         mOpCycle = 0;
  int         mStart = -1;
  int         mFrames = 0;
  logic [7:0] mA = 0;
  logic [7:0] mB = 0;
  logic [7:0] mOp = 0;
  logic [7:0] mResult = 0;

  alu_uart_sequencer #(
    .DATA_WIDTH(8),
    .ALU_LATENCY(LAT),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .alu_result(alu_result),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .reg_data(reg_data),
    .load_a(load_a),
    .load_b(load_b),
    .load_op(load_op),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .busy(busy),
    .timeout(timeout),
    .overrun(overrun),
    .state_dbg(state_dbg),
    .frame_count(frame_count)
  );

  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    case (op[1:0])
      2'd0:    aluRef = a + b;
      2'd1:    aluRef = a - b;
      2'd2:    aluRef = a ^ b;
      default: aluRef = a & b;
    endcase
  endfunction

  assign w_outs = {30'b0, reg_data, load_a, load_b, load_op, tx_data, tx_start,
                   busy, timeout, overrun, state_dbg, frame_count};

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index shared by the model and the monitor
  always @(posedge clk) cyc <= cyc + 1;

  // Operand/opcode registers and a combinational ALU, standing in for the datapath
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stubA <= 8'h00; stubB <= 8'h00; stubOp <= 8'h00;
    end else begin
      if (load_a)  stubA  <= reg_data;
      if (load_b)  stubB  <= reg_data;
      if (load_op) stubOp <= reg_data;
    end
  end
  assign alu_result = aluRef(stubA, stubB, stubOp);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (!reset) begin
      if (load_a || load_b || load_op || tx_start || timeout) begin
        logic [4:0] actKinds;
        logic [7:0] actData;
        ev_t e;
        actKinds = {timeout, tx_start, load_op, load_b, load_a};
        actData = (load_a || load_b || load_op) ? reg_data : (tx_start ? tx_data : 8'h00);
        if (expQ.size() == 0) begin
          checkOutput("unexpected strobe", {59'b0, actKinds}, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("strobe kind", {59'b0, actKinds}, {59'b0, e.kinds});
          checkOutput("strobe data", {56'b0, actData}, {56'b0, e.data});
          checkOutput("strobe cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (overrun) begin
        if (ovrQ.size() == 0) begin
          checkOutput("unexpected overrun", {63'b0, overrun}, 64'd0);
        end else begin
          checkOutput("overrun cycle", 64'(cyc), 64'(ovrQ.pop_front()));
          checkOutput("overrun no load", {61'b0, load_a, load_b, load_op}, 64'd0);
        end
      end
    end
  end

  // Drive one cycle of inputs, advance the model, and move to the next cycle
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic b, input logic dn);
    int n;
    n = cyc;
    rx_valid = v; rx_data = d; tx_busy = b; tx_done = dn;
    if (mInFlight) begin
      if (v) ovrQ.push_back(n + 1);
      if (mStart < 0) begin
        if (n >= mOpCycle + LAT && !b) begin
          mStart = n + 1;
          expQ.push_back('{5'b01000, mResult, n + 1});
        end
      end else if (n >= mStart && dn) begin
        mFrames++;
        mInFlight = 0;
        mCount = 0;
      end
    end else begin
      if (mCount > 0 && n >= mLastLoad + TMO) begin
        expQ.push_back('{5'b10000, 8'h00, n});
        mCount = 0;
      end
      if (v) begin
        case (mCount)
          0: begin mA = d; expQ.push_back('{5'b00001, d, n + 1}); end
          1: begin mB = d; expQ.push_back('{5'b00010, d, n + 1}); end
          default: begin
            mOp = d;
            expQ.push_back('{5'b00100, d, n + 1});
            mInFlight = 1;
            mOpCycle = n + 1;
            mStart = -1;
            mResult = aluRef(mA, mB, mOp);
          end
        endcase
        mLastLoad = n + 1;
        mCount++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input int gap);
    repeat (gap) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
  endtask

  // Carry an in-flight result through busy hold, tx_start, transmission and tx_done
  task automatic finishFrame(input int busyCycles, input int doneDelay, input int ovrAt);
    int guard;
    guard = 0;
    for (int i = 0; i < busyCycles; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (mInFlight && mStart < 0) checkOutput("busy in flight", {63'b0, busy}, 64'd1);
      if (mInFlight && mStart < 0 && cyc >= mOpCycle + LAT)
        checkOutput("tx_data held", {56'b0, tx_data}, {56'b0, mResult});
    end
    while (mInFlight && mStart < 0 && guard < 200) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    for (int i = 0; i < doneDelay; i++) applyStimulus(i == ovrAt, 8'h55, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("frame_count", {56'b0, frame_count}, 64'(mFrames % 256));
    checkOutput("state after frame", {61'b0, state_dbg}, 64'd0);
    checkOutput("busy after frame", {63'b0, busy}, 64'd0);
  endtask

  task automatic pulseReset();
    reset = 1'b1; rx_valid = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    #1;
    checkOutput("async reset outputs", w_outs, 64'd0);
    expQ.delete();
    ovrQ.delete();
    mCount = 0; mInFlight = 0; mFrames = 0; mStart = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int gapRand();
    if ($urandom_range(0, 19) == 0) gapRand = int'($urandom_range(TMO - 5, TMO + 5));
    else gapRand = int'($urandom_range(0, 4));
  endfunction

  initial begin
    int guard;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset outputs", w_outs, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Nominal frame, bytes 20 cycles apart: 0x12 + 0x34 = 0x46
    sendByte(8'h12, 0);
    checkOutput("state WAIT_B", {61'b0, state_dbg}, 64'd1);
    checkOutput("busy WAIT_B", {63'b0, busy}, 64'd1);
    sendByte(8'h34, 19);
    sendByte(8'h00, 19);
    finishFrame(0, 5, -1);

    // Abandoned frame times out, then a fresh frame 1 + 2 = 3
    sendByte(8'hAA, 0);
    repeat (120) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("state after timeout", {61'b0, state_dbg}, 64'd0);
    sendByte(8'h01, 2);
    sendByte(8'h02, 2);
    sendByte(8'h00, 2);
    finishFrame(0, 3, -1);

    // Byte on the last allowed cycle wins over the timeout
    sendByte(8'h21, 0);
    sendByte(8'h22, TMO - 1);
    sendByte(8'h02, 0);
    finishFrame(0, 2, -1);

    // Byte one cycle later loses: timeout, then it starts a new frame
    sendByte(8'h31, 0);
    sendByte(8'h32, TMO);
    sendByte(8'h33, 1);
    sendByte(8'h01, 1);
    finishFrame(0, 2, -1);

    // Busy transmitter held for 30 cycles
    sendByte(8'h0F, 1);
    sendByte(8'hF0, 1);
    sendByte(8'h02, 1);
    finishFrame(30, 4, -1);

    // Overrun during EXEC and during WAIT_TX
    sendByte(8'h40, 0);
    sendByte(8'h05, 0);
    sendByte(8'h01, 0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    finishFrame(2, 5, 2);

    // Reset mid-WAIT_OP
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("state WAIT_OP", {61'b0, state_dbg}, 64'd2);
    pulseReset();

    // Reset mid-WAIT_TX
    sendByte(8'h07, 0);
    sendByte(8'h08, 0);
    sendByte(8'h00, 0);
    guard = 0;
    while (mStart < 0 && guard < 50) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("state WAIT_TX", {61'b0, state_dbg}, 64'd5);
    pulseReset();

    // Randomised frames until the frame counter has wrapped past 255
    guard = 0;
    while (mFrames < 258 && guard < 3000) begin
      for (int k = 0; k < 3; k++) sendByte(8'($urandom), gapRand());
      if (mInFlight && $urandom_range(0, 3) == 0) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      if (mInFlight)
        finishFrame(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);
      guard++;
    end
    checkOutput("frames completed", 64'(mFrames), 64'd258);

    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pending strobes", 64'(expQ.size()), 64'd0);
    checkOutput("pending overruns", 64'(ovrQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
